// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial operand feeder.
//   state_e          - FSM states of serial_operand_shifter (IDLE, SHIFT)
//   SERIAL_MAX_WIDTH - default largest operand length in bits
//   serial_len_w()   - width needed to hold a length of 0..max_width
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int SERIAL_MAX_WIDTH = 8;

    function automatic int serial_len_w(input int max_width);
        return $clog2(max_width) + 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register, LSB first.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset, clears the register
//   load_i  - load data_i (has priority over shift_i)
//   shift_i - shift right by one, zero enters at the MSB
//   data_i  - parallel load value
//   ser_o   - serial output, always bit 0 of the register
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_MAX_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_o = sr_q[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter: feeds a bit-serial adder. Accepts two parallel
// operands, an initial carry and a length through valid/ready, then streams
// the operands LSB-first one bit per clock. Holds the adder's reset high
// between operations so every addition starts from a cleared carry.
//
// Optional build macro SERIAL_SHIFTER_EXTRA_BIT_EN: appends one zero bit
// after the operand bits so the adder's final carry reaches its sum output;
// last_bit then marks that extra cycle.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   in_valid / in_ready   - operand handshake (in_ready only in IDLE)
//   op_a, op_b            - operands, bit 0 = LSB
//   op_cin                - initial carry, driven on bit 0 only
//   op_len                - bits to stream; 0 or > MAX_WIDTH means MAX_WIDTH
//   abort                 - cancel the stream in progress
//   a, b, cin             - serial bits to the adder
//   adder_reset           - reset for the downstream adder
//   bit_valid             - a/b/cin carry a live bit
//   first_bit, last_bit   - marks on the first / final streamed bit
//   done, aborted         - one-cycle pulses after completion / abort
module serial_operand_shifter
    import serial_pkg::*;
#(
    parameter int MAX_WIDTH = SERIAL_MAX_WIDTH,
    parameter int LEN_W     = serial_len_w(MAX_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAX_WIDTH-1:0] op_a,
    input  logic [MAX_WIDTH-1:0] op_b,
    input  logic                 op_cin,
    input  logic [LEN_W-1:0]     op_len,
    input  logic                 abort,
    output logic                 a,
    output logic                 b,
    output logic                 cin,
    output logic                 adder_reset,
    output logic                 bit_valid,
    output logic                 first_bit,
    output logic                 last_bit,
    output logic                 done,
    output logic                 aborted
);

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     last_idx_q, last_idx_d;
    logic                 cin_q, cin_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 adder_reset_q, adder_reset_d;

    logic                 hs;
    logic                 load_en;
    logic                 shift_en;
    logic [LEN_W-1:0]     eff_len;
    logic [LEN_W-1:0]     new_last;
    logic [LEN_W-1:0]     cnt_nxt;
    logic [MAX_WIDTH-1:0] load_mask;

    assign in_ready = (state_q == IDLE) && !reset;
    assign hs       = in_valid && in_ready;
    assign cnt_nxt  = cnt_q + 1'b1;

    // Effective length, index of the final streamed bit, and a mask that
    // zeroes operand bits above the length. The mask keeps the serial outputs
    // at zero once the real bits are exhausted, which also provides the zero
    // operands of the optional extra cycle.
    always_comb begin
        if (op_len == '0 || int'(op_len) > MAX_WIDTH) begin
            eff_len = LEN_W'(MAX_WIDTH);
        end else begin
            eff_len = op_len;
        end
`ifdef SERIAL_SHIFTER_EXTRA_BIT_EN
        new_last = eff_len;
`else
        new_last = eff_len - 1'b1;
`endif
        load_mask = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            load_mask[i] = (i < int'(eff_len));
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_idx_d    = last_idx_q;
        cin_d         = 1'b0;
        bit_valid_d   = 1'b0;
        first_d       = 1'b0;
        last_d        = 1'b0;
        done_d        = 1'b0;
        aborted_d     = 1'b0;
        adder_reset_d = 1'b1;
        load_en       = 1'b0;
        shift_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    load_en       = 1'b1;
                    state_d       = SHIFT;
                    cnt_d         = '0;
                    last_idx_d    = new_last;
                    cin_d         = op_cin;
                    bit_valid_d   = 1'b1;
                    first_d       = 1'b1;
                    last_d        = (new_last == '0);
                    adder_reset_d = 1'b0;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (abort) begin
                    // Abort wins even over the final bit: no done pulse.
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == last_idx_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d         = cnt_nxt;
                    bit_valid_d   = 1'b1;
                    last_d        = (cnt_nxt == last_idx_q);
                    adder_reset_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_idx_q    <= '0;
            cin_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            adder_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_idx_q    <= last_idx_d;
            cin_q         <= cin_d;
            bit_valid_q   <= bit_valid_d;
            first_q       <= first_d;
            last_q        <= last_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            adder_reset_q <= adder_reset_d;
        end
    end

    piso_shift_reg #(.WIDTH(MAX_WIDTH)) u_sr_a (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (load_en),
        .shift_i (shift_en),
        .data_i  (op_a & load_mask),
        .ser_o   (a)
    );

    piso_shift_reg #(.WIDTH(MAX_WIDTH)) u_sr_b (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (load_en),
        .shift_i (shift_en),
        .data_i  (op_b & load_mask),
        .ser_o   (b)
    );

    assign cin         = cin_q;
    assign bit_valid   = bit_valid_q;
    assign first_bit   = first_q;
    assign last_bit    = last_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign adder_reset = adder_reset_q;

endmodule

// File: tb/tb_serial_operand_shifter.sv
module tb_serial_operand_shifter;

    localparam int MW = 8;
    localparam int LW = 4;
`ifdef SERIAL_SHIFTER_EXTRA_BIT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] op_a, op_b;
    logic          op_cin;
    logic [LW-1:0] op_len;
    logic          abort;
    logic          a, b, cin, adder_reset, bit_valid, first_bit, last_bit, done, aborted;

    serial_operand_shifter #(.MAX_WIDTH(MW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_len(op_len), .abort(abort),
        .a(a), .b(b), .cin(cin), .adder_reset(adder_reset), .bit_valid(bit_valid),
        .first_bit(first_bit), .last_bit(last_bit), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one transaction record plus the index of the bit on
    // the wire; expected outputs follow from indexing the latched operands.
    bit          m_busy = 0;
    logic [MW-1:0] m_a, m_b;
    logic        m_c;
    int          m_L, m_i;
    int          edge_n = 0;
    int          hs_edge = 0;

    // Observed-stream capture used by the directed checks.
    logic [MW:0] cap_a, cap_b, cap_c, d_a, d_b, d_c;
    int          cap_n = 0, d_n = 0, d_lat = 0;
    int          ndone = 0, nabort = 0;
    int          gap = 0, last_gap = 0;
    bit          saw_both = 0;

    always @(posedge clk) begin
        bit e_done, e_abt, e_rst, e_bv;
        int e_now;
        e_done = 0; e_abt = 0; e_rst = 0;
        e_now  = edge_n;
        if (reset) begin
            m_busy = 0;
            e_rst  = 1;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_a = op_a; m_b = op_b; m_c = op_cin;
                m_L = (op_len == 0 || int'(op_len) > MW) ? MW : int'(op_len);
                m_i = 0; m_busy = 1; hs_edge = e_now;
            end
        end else if (abort) begin
            m_busy = 0; e_abt = 1;
        end else if (m_i == m_L + EXTRA - 1) begin
            m_busy = 0; e_done = 1;
        end else begin
            m_i++;
        end
        edge_n++;
        #1;
        e_bv = m_busy;
        chk("in_ready",    {31'd0, in_ready},    {31'd0, !m_busy && !reset});
        chk("bit_valid",   {31'd0, bit_valid},   {31'd0, e_bv});
        chk("adder_reset", {31'd0, adder_reset}, {31'd0, !e_bv});
        chk("first_bit",   {31'd0, first_bit},   {31'd0, e_bv && m_i == 0});
        chk("last_bit",    {31'd0, last_bit},    {31'd0, e_bv && m_i == m_L + EXTRA - 1});
        chk("cin",         {31'd0, cin},         {31'd0, e_bv && m_i == 0 && m_c});
        chk("done",        {31'd0, done},        {31'd0, e_done});
        chk("aborted",     {31'd0, aborted},     {31'd0, e_abt});
        if (e_bv) begin
            chk("a", {31'd0, a}, {31'd0, (m_i < m_L) ? m_a[m_i] : 1'b0});
            chk("b", {31'd0, b}, {31'd0, (m_i < m_L) ? m_b[m_i] : 1'b0});
        end else if (e_rst) begin
            chk("a_reset", {31'd0, a}, 32'd0);
            chk("b_reset", {31'd0, b}, 32'd0);
        end
        // capture what the DUT actually streamed
        if (adder_reset) gap++;
        if (bit_valid) begin
            if (first_bit) begin
                cap_a = '0; cap_b = '0; cap_c = '0; cap_n = 0;
                last_gap = gap; gap = 0;
            end
            if (first_bit && last_bit) saw_both = 1;
            if (cap_n <= MW) begin
                cap_a[cap_n] = a; cap_b[cap_n] = b; cap_c[cap_n] = cin;
            end
            cap_n++;
        end
        if (done) begin
            d_a = cap_a; d_b = cap_b; d_c = cap_c; d_n = cap_n;
            d_lat = e_now - hs_edge;
            ndone++;
        end
        if (aborted) nabort++;
    end

    // Called at a negedge; the handshake happens at the next posedge and
    // the task returns at the negedge inside the bit-0 cycle.
    task automatic start(input logic [MW-1:0] va, input logic [MW-1:0] vb,
                         input logic vc, input logic [LW-1:0] vl);
        in_valid = 1; op_a = va; op_b = vb; op_cin = vc; op_len = vl;
        @(negedge clk);
        in_valid = 0;
        op_a = MW'($urandom); op_b = MW'($urandom); op_cin = 1'($urandom); op_len = LW'($urandom);
    endtask

    initial begin
        logic [MW-1:0] ra, rb;
        int nd0, na0;
        reset = 1; in_valid = 0; op_a = '0; op_b = '0; op_cin = 0; op_len = '0; abort = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);

        // 4'b1111 + 4'b1101, cin=1, then back-to-back 5-bit operation in the done cycle
        nd0 = ndone;
        start(8'h0F, 8'h0D, 1'b1, 4'd4);
        repeat (4 + EXTRA) @(negedge clk);
        chk("t1_a",    32'(d_a), 32'h0F);
        chk("t1_b",    32'(d_b), 32'h0D);
        chk("t1_cin",  32'(d_c), 32'h01);
        chk("t1_len",  d_n,      4 + EXTRA);
        chk("t1_lat",  d_lat,    4 + EXTRA);
        chk("t1_done", ndone,    nd0 + 1);
        start(8'h1B, 8'h11, 1'b1, 4'd5);
        repeat (5 + EXTRA) @(negedge clk);
        chk("t2_a",   32'(d_a), 32'h1B);
        chk("t2_b",   32'(d_b), 32'h11);
        chk("t2_cin", 32'(d_c), 32'h01);
        chk("t2_len", d_n,      5 + EXTRA);
        chk("t2_gap", last_gap, 1);

        // length clamping and the single-bit stream
        ra = MW'($urandom); rb = MW'($urandom);
        start(ra, rb, 1'b0, 4'd0);
        repeat (MW + EXTRA) @(negedge clk);
        chk("len0_a",   32'(d_a), 32'({1'b0, ra}));
        chk("len0_len", d_n, MW + EXTRA);
        ra = MW'($urandom); rb = MW'($urandom);
        start(ra, rb, 1'b1, LW'(MW + 3));
        repeat (MW + EXTRA) @(negedge clk);
        chk("lenbig_b",   32'(d_b), 32'({1'b0, rb}));
        chk("lenbig_len", d_n, MW + EXTRA);
        saw_both = 0;
        ra = MW'($urandom); rb = MW'($urandom);
        start(ra, rb, 1'b1, 4'd1);
        repeat (1 + EXTRA) @(negedge clk);
        chk("len1_a",    32'(d_a), 32'({8'd0, ra[0]}));
        chk("len1_len",  d_n,   1 + EXTRA);
        chk("len1_lat",  d_lat, 1 + EXTRA);
        chk("len1_both", {31'd0, saw_both}, {31'd0, EXTRA == 0});
        @(negedge clk);

        // abort on bit 2, then abort coincident with the last bit
        nd0 = ndone; na0 = nabort;
        start(8'hA5, 8'h3C, 1'b1, 4'd4);
        repeat (2) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort2_pulse", nabort, na0 + 1);
        repeat (3) @(negedge clk);
        chk("abort2_nodone", ndone, nd0);
        start(8'h5A, 8'hC3, 1'b0, 4'd4);
        repeat (3 + EXTRA) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        repeat (2) @(negedge clk);
        chk("abortlast_pulse",  nabort, na0 + 2);
        chk("abortlast_nodone", ndone,  nd0);

        // reset on bit 1 with in_valid held high during reset
        nd0 = ndone; na0 = nabort;
        start(8'hFF, 8'hFF, 1'b1, 4'd4);
        @(negedge clk);
        reset = 1; in_valid = 1;
        repeat (2) @(negedge clk);
        reset = 0; in_valid = 0;
        repeat (6) @(negedge clk);
        chk("rst_nodone",  ndone,  nd0);
        chk("rst_noabort", nabort, na0);

        // in_valid while streaming is ignored
        start(8'h96, 8'h69, 1'b0, 4'd6);
        @(negedge clk);
        in_valid = 1; op_a = 8'hFF; op_b = 8'h00; op_len = 4'd2;
        repeat (3) @(negedge clk);
        in_valid = 0;
        repeat (2 + EXTRA) @(negedge clk);
        chk("busy_a",   32'(d_a), 32'h16);
        chk("busy_b",   32'(d_b), 32'h29);
        chk("busy_len", d_n, 6 + EXTRA);
        @(negedge clk);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            op_a   = MW'($urandom);
            op_b   = MW'($urandom);
            op_cin = 1'($urandom);
            op_len = LW'($urandom);
            abort  = ($urandom_range(0, 11) == 0);
            reset  = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        in_valid = 0; abort = 0; reset = 0;
        repeat (MW + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
